irq_sequencer: RTL
==================

Name: irq_sequencer

Overview:
- Four-channel interrupt request sequencer that sits directly upstream of the 4-bit priority encoder.
- Edge-detects raw request lines and latches them into a pending register, which drives the encoder input.
- Qualifies pending requests with a mask and presents the highest-priority one on an irq/vec/ack handshake to the consumer.
- Priority convention matches the encoder: channel index 0 is highest and 3 is lowest. vec uses the same 2-bit code as the encoder: ch0=00, ch1=01, ch2=10, ch3=11.

Parameters:
TIMEOUT, 15, number of cycles irq stays asserted without ack before abandoning; 0 disables the timeout
TW, 4, width of the timeout counter; must satisfy TIMEOUT < 2**TW

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  [0:3]  raw request lines, synchronous to clk; bit 0 highest priority
mask  input  [0:3]  1 = channel masked; it still latches pending but is never selected
ack  input  1  consumer acknowledge; sampled only in ASSERT
clr_miss  input  1  synchronous clear of all miss flags
pend  output  [0:3]  pending register, drives the priority encoder input
irq  output  1  interrupt request to consumer
vec  output  [0:1]  code of the channel being serviced; valid while irq=1
miss  output  [0:3]  sticky flag per channel: rising edge seen while already pending
tmo  output  1  one-cycle pulse when an irq is abandoned on timeout

Behaviour:
- Reset (rst_n low, asynchronous):
  - pend=0000, irq=0, vec=00, miss=0000, tmo=0.
  - Internal req_q=0000, state=IDLE, timeout counter=0.
- Reset asserted mid-handshake aborts immediately; no pending bit survives.
- Edge detect: rise[i] = req[i] & ~req_q[i]. req_q <= req every cycle.
  - A request already high at reset release produces a rise on the first active edge.
- Pending update, per channel, every cycle:
  - Set on rise[i].
  - Cleared on the edge where ack is accepted for that channel.
  - Set wins over clear on the same edge; no miss flag in that case.
- Miss: rise[i] while pend[i]=1 and pend[i] is not being cleared on that edge -> miss[i]<=1.
  - Sticky until clr_miss=1. If clr_miss and a new miss coincide, set wins.
- Eligible set: elig = pend & ~mask. Selection is the lowest index i with elig[i]=1.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: irq=0. If elig != 0 -> ASSERT; vec <= selected code, counter <= 0, irq <= 1.
  - ASSERT: irq=1, vec frozen. A newly pending higher-priority channel does not preempt. Masking the serviced channel mid-handshake does not withdraw irq.
    - ack=1 -> clear pend[vec], irq <= 0, go to GAP.
    - Else, if TIMEOUT != 0 and counter == TIMEOUT-1 -> irq <= 0, tmo <= 1 for one cycle, pend unchanged, go to GAP.
    - Else counter increments.
    - ack and timeout on the same edge: ack wins, no tmo.
  - GAP: one cycle with irq=0, then IDLE unconditionally. This guarantees at least one low cycle between requests.
- Latency:
  - req rises, sampled at edge k -> pend[i]=1 after k -> irq=1 after k+1.
  - ack sampled at edge j -> irq=0 and pend cleared after j -> IDLE after j+1 -> next irq earliest after j+2.
  - The minimum handshake is therefore 3 cycles per interrupt.
- ack outside ASSERT is ignored.
- vec holds its last value while irq=0.
- Level-held req does not re-trigger; the line must fall and rise again to re-pend.

Test Plan:
1. Reset then single request: req=0010 at edge 2 -> pend=0010 after edge 2, irq=1, vec=10 after edge 3. ack at edge 5 -> irq=0, pend=0000 after edge 5.
2. Simultaneous requests: req=1010 rises together -> vec=00 first; after ack and GAP, vec=10. Exactly two irq pulses, with irq low for at least 1 cycle between them.
3. Masking and no preemption:
   - mask=1000, req=1001 -> vec=11 served, ch0 stays pending.
   - Clear mask and ack -> next vec=00.
   - Raise ch0 during ch3 ASSERT -> vec stays 11.
4. Miss and set-wins:
   - Pulse req[1] twice before ack -> miss=0100; clr_miss -> 0000.
   - Rise on ch1 on the same edge as its ack -> pend[1] stays 1, miss unchanged.
5. Timeout with TIMEOUT=4: never ack -> irq high for exactly 4 cycles, tmo one-cycle pulse, pend unchanged, irq reasserts with the same vec after GAP+IDLE. With TIMEOUT=0, irq holds indefinitely.
6. Async reset mid-ASSERT: drop rst_n between clock edges -> irq, pend, vec and miss go to 0 immediately without a clock. After release with req held high -> new rise and a fresh irq.

Source files
------------

// File: rtl/irq_sequencer.sv
// ============================================================================
// Module   : irq_sequencer
// Brief    : Four-channel edge-detecting interrupt sequencer with mask, fixed
//            priority (ch0 highest), irq/vec/ack handshake and irq timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:3] req,
  input  logic [0:3] mask,
  input  logic       ack,
  input  logic       clr_miss,
  output logic [0:3] pend,
  output logic       irq,
  output logic [0:1] vec,
  output logic [0:3] miss,
  output logic       tmo
);

  localparam logic [1:0]    c_S_IDLE   = 2'd0;
  localparam logic [1:0]    c_S_ASSERT = 2'd1;
  localparam logic [1:0]    c_S_GAP    = 2'd2;
  localparam bit            c_TMO_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] c_TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [0:3]    req_q;
  logic [0:3]    pend_q, pend_d;
  logic [0:3]    miss_q, miss_d;
  logic [0:1]    vec_q, vec_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  logic [0:3]    w_rise;
  logic [0:3]    w_elig;
  logic [0:3]    w_clr;
  logic [0:1]    w_sel;
  logic          w_ack_acc;
  logic          w_tmo_hit;

  assign w_rise    = req & ~req_q;
  assign w_elig    = pend_q & ~mask;
  assign w_ack_acc = (state_q == c_S_ASSERT) && ack;
  assign w_tmo_hit = c_TMO_EN && (cnt_q == c_TMO_LAST);

  // Descending scan so the lowest eligible index is the one left in w_sel.
  always_comb begin
    w_sel = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (w_elig[i]) w_sel = 2'(i);
    end
  end

  always_comb begin
    w_clr = 4'b0000;
    if (w_ack_acc) w_clr[vec_q] = 1'b1;
  end

  // A rise re-sets pend even on the clearing edge, and only counts as a miss
  // when the pending bit would otherwise have survived.
  always_comb begin
    pend_d = (pend_q & ~w_clr) | w_rise;
    miss_d = (clr_miss ? 4'b0000 : miss_q) | (w_rise & pend_q & ~w_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_S_IDLE;
      req_q   <= 4'b0000;
      pend_q  <= 4'b0000;
      miss_q  <= 4'b0000;
      vec_q   <= 2'b00;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      pend_q  <= pend_d;
      miss_q  <= miss_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      c_S_IDLE: begin
        if (w_elig != 4'b0000) begin
          state_d = c_S_ASSERT;
          vec_d   = w_sel;
          cnt_d   = '0;
        end
      end
      c_S_ASSERT: begin
        if (ack) begin
          state_d = c_S_GAP;
        end else if (w_tmo_hit) begin
          state_d = c_S_GAP;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      c_S_GAP:  state_d = c_S_IDLE;
      default:  state_d = c_S_IDLE;
    endcase
  end

  always_comb begin
    irq  = (state_q == c_S_ASSERT);
    vec  = vec_q;
    pend = pend_q;
    miss = miss_q;
    tmo  = tmo_q;
  end

endmodule

`default_nettype wire
